cpu_jtag_ocimem_ctrl: RTL and testbench



---
 rtl/cpu_jtag_ocimem_ctrl.sv | 126 ++++++++++++
 tb/tb_cpu_jtag_ocimem_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_jtag_ocimem_ctrl.sv
// Decodes JTAG debug-module ocimem commands into single-word transactions on the
// on-chip debug memory port, with an auto-incrementing address and a per-transaction timeout.
module cpu_jtag_ocimem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] mon_address,
  output logic              mon_read,
  output logic              mon_write,
  output logic [31:0]       mon_writedata,
  input  logic [31:0]       mon_readdata,
  input  logic              mon_waitrequest,
  input  logic              mon_readdatavalid
);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         dreg_q, dreg_d;
  logic                err_q, err_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                any_pulse;
  logic                rd_done;
  logic                wr_done;
  logic                unused_jdo;

  // Only the address, read-flag and data fields of jdo are decoded.
  assign unused_jdo = ^jdo;

  assign any_pulse = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dreg_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dreg_q  <= dreg_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    dreg_d  = dreg_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rd_done = 1'b0;
    wr_done = 1'b0;

    if (state_q == IDLE) begin
      // Priority b > a > no_action; losing pulses are dropped.
      if (take_action_ocimem_b) begin
        dreg_d  = jdo[34:3];
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = WR_REQ;
      end else if (take_action_ocimem_a) begin
        addr_d  = jdo[ADDR_W+1:2];
        err_d   = 1'b0;
        cnt_d   = '0;
        if (jdo[17]) state_d = RD_REQ;
      end else if (take_no_action_ocimem_a) begin
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = RD_REQ;
      end
    end else begin
      cnt_d = cnt_q + 16'd1;
      if (any_pulse) err_d = 1'b1;

      case (state_q)
        RD_REQ: begin
          if (!mon_waitrequest) begin
            if (mon_readdatavalid) rd_done = 1'b1;
            else                   state_d = RD_WAIT;
          end
        end
        RD_WAIT: rd_done = mon_readdatavalid;
        WR_REQ:  wr_done = !mon_waitrequest;
        default: ;
      endcase

      // A completion on the timeout edge takes precedence over the abort.
      if (rd_done || wr_done) begin
        if (rd_done) dreg_d = mon_readdata;
        addr_d  = addr_q + 1'b1;
        state_d = IDLE;
      end else if (cnt_d == TIMEOUT_CNT) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end
  end

  assign MonDReg       = dreg_q;
  assign mon_writedata = dreg_q;
  assign mon_address   = addr_q;
  assign monitor_error = err_q;
  assign monitor_ready = (state_q == IDLE);
  assign mon_read      = (state_q == RD_REQ);
  assign mon_write     = (state_q == WR_REQ);

endmodule

// File: tb/tb_cpu_jtag_ocimem_ctrl.sv
// Directed bench for cpu_jtag_ocimem_ctrl: commands, slave handshakes, wrap,
// timeout (TIMEOUT=4), busy pulses and simultaneous pulses.
module tb_cpu_jtag_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  mon_address;
  logic        mon_read, mon_write;
  logic [31:0] mon_writedata, mon_readdata;
  logic        mon_waitrequest, mon_readdatavalid;

  int n_cmp = 0;
  int n_bad = 0;

  int          rd_cyc, wr_cyc;
  logic [31:0] wdata_seen;
  logic [7:0]  addr_seen;
  logic        addr_stable, done;

  cpu_jtag_ocimem_ctrl #(.ADDR_W(8), .TIMEOUT(4)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .mon_address             (mon_address),
    .mon_read                (mon_read),
    .mon_write               (mon_write),
    .mon_writedata           (mon_writedata),
    .mon_readdata            (mon_readdata),
    .mon_waitrequest         (mon_waitrequest),
    .mon_readdatavalid       (mon_readdatavalid)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] jdo_addr(input logic [7:0] addr, input logic rd);
    return (38'(addr) << 2) | (38'(rd) << 17);
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] data);
    return 38'(data) << 3;
  endfunction

  // Drive command pulses for exactly the next clock edge.
  task automatic issue(input logic a, input logic b, input logic na, input logic [37:0] word);
    @(negedge clk);
    take_action_ocimem_a    = a;
    take_action_ocimem_b    = b;
    take_no_action_ocimem_a = na;
    jdo                     = word;
  endtask

  // Play the slave after a command: waitrequest high for wait_cycles request
  // cycles, readdatavalid on cycle rdv_at, optional busy pulse on cycle pulse_at.
  task automatic run_txn(input int wait_cycles, input int rdv_at, input logic [31:0] rdata,
                         input int pulse_at);
    rd_cyc = 0; wr_cyc = 0; wdata_seen = '0; addr_seen = '0; addr_stable = 1'b1; done = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      take_action_ocimem_a    = 1'b0;
      take_action_ocimem_b    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      if (mon_read || mon_write) begin
        if (rd_cyc + wr_cyc == 0) begin
          addr_seen  = mon_address;
          wdata_seen = mon_writedata;
        end else if (mon_address !== addr_seen) begin
          addr_stable = 1'b0;
        end
        if (mon_read)  rd_cyc++;
        if (mon_write) wr_cyc++;
      end
      if (monitor_ready) begin
        done = 1'b1;
        break;
      end
      mon_waitrequest   = (c <= wait_cycles);
      mon_readdatavalid = (c == rdv_at);
      mon_readdata      = rdata;
      if (c == pulse_at) begin
        take_action_ocimem_b = 1'b1;
        jdo                  = jdo_data(32'h1111_1111);
      end
    end
    mon_waitrequest   = 1'b0;
    mon_readdatavalid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (MonDReg !== 32'h0) begin n_bad++; $display("FAIL reset_dreg: got %h want 0", MonDReg); end
    n_cmp++; if ({monitor_ready, monitor_error} !== 2'b10) begin n_bad++; $display("FAIL reset_flags: got ready/err %b want 10", {monitor_ready, monitor_error}); end
    n_cmp++; if ({mon_read, mon_write} !== 2'b00) begin n_bad++; $display("FAIL reset_req: got rd/wr %b want 00", {mon_read, mon_write}); end
    n_cmp++; if (mon_address !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h want 00", mon_address); end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({monitor_ready, mon_read, mon_write} !== 3'b100) begin n_bad++; $display("FAIL idle_after_reset: got %b want 100", {monitor_ready, mon_read, mon_write}); end
  endtask

  task automatic test_addr_read;
    issue(1'b1, 1'b0, 1'b0, jdo_addr(8'h10, 1'b1));
    run_txn(2, 4, 32'hDEAD_BEEF, 0);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rd_done: got %b want 1", done); end
    n_cmp++; if (rd_cyc !== 3) begin n_bad++; $display("FAIL rd_hold: got %0d want 3", rd_cyc); end
    n_cmp++; if (addr_seen !== 8'h10 || addr_stable !== 1'b1) begin n_bad++; $display("FAIL rd_req_addr: got %h stable %b want 10 stable 1", addr_seen, addr_stable); end
    n_cmp++; if (MonDReg !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", MonDReg); end
    n_cmp++; if (mon_address !== 8'h11) begin n_bad++; $display("FAIL rd_incr: got %h want 11", mon_address); end
    n_cmp++; if (monitor_error !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b want 0", monitor_error); end
  endtask

  task automatic test_write_read_next;
    issue(1'b0, 1'b1, 1'b0, jdo_data(32'h1234_5678));
    run_txn(0, 0, 32'h0, 0);
    n_cmp++; if (wr_cyc !== 1 || rd_cyc !== 0) begin n_bad++; $display("FAIL wr_cycles: got wr %0d rd %0d want 1 0", wr_cyc, rd_cyc); end
    n_cmp++; if (wdata_seen !== 32'h1234_5678 || addr_seen !== 8'h11) begin n_bad++; $display("FAIL wr_bus: got %h @%h want 12345678 @11", wdata_seen, addr_seen); end
    n_cmp++; if (mon_address !== 8'h12 || MonDReg !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_after: got addr %h dreg %h want 12 12345678", mon_address, MonDReg); end
    issue(1'b0, 1'b0, 1'b1, 38'h0);
    run_txn(0, 2, 32'hCAFE_F00D, 0);
    n_cmp++; if (rd_cyc !== 1 || addr_seen !== 8'h12) begin n_bad++; $display("FAIL rdnext_bus: got %0d cyc @%h want 1 @12", rd_cyc, addr_seen); end
    n_cmp++; if (MonDReg !== 32'hCAFE_F00D || mon_address !== 8'h13) begin n_bad++; $display("FAIL rdnext_after: got %h addr %h want cafef00d 13", MonDReg, mon_address); end
    // Data valid on the same edge the request is accepted.
    issue(1'b0, 1'b0, 1'b1, 38'h0);
    run_txn(0, 1, 32'h0BAD_F00D, 0);
    n_cmp++; if (MonDReg !== 32'h0BAD_F00D || mon_address !== 8'h14 || rd_cyc !== 1) begin n_bad++; $display("FAIL rd_direct: got %h addr %h cyc %0d want 0badf00d 14 1", MonDReg, mon_address, rd_cyc); end
  endtask

  task automatic test_wrap;
    issue(1'b1, 1'b0, 1'b0, jdo_addr(8'hFF, 1'b0));
    run_txn(0, 0, 32'h0, 0);
    n_cmp++; if (mon_address !== 8'hFF || rd_cyc !== 0 || done !== 1'b1) begin n_bad++; $display("FAIL load_noread: got addr %h rd %0d done %b want ff 0 1", mon_address, rd_cyc, done); end
    issue(1'b0, 1'b1, 1'b0, jdo_data(32'hA5A5_A5A5));
    run_txn(0, 0, 32'h0, 0);
    n_cmp++; if (addr_seen !== 8'hFF || mon_address !== 8'h00 || monitor_error !== 1'b0) begin n_bad++; $display("FAIL wrap: got @%h next %h err %b want ff 00 0", addr_seen, mon_address, monitor_error); end
  endtask

  task automatic test_timeout;
    issue(1'b1, 1'b0, 1'b0, jdo_addr(8'h40, 1'b1));
    run_txn(100, 0, 32'h0, 0);
    n_cmp++; if (rd_cyc !== 4) begin n_bad++; $display("FAIL to_hold: got %0d want 4", rd_cyc); end
    n_cmp++; if ({monitor_ready, monitor_error, mon_read} !== 3'b110) begin n_bad++; $display("FAIL to_flags: got rdy/err/rd %b want 110", {monitor_ready, monitor_error, mon_read}); end
    n_cmp++; if (mon_address !== 8'h40 || MonDReg !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL to_keep: got addr %h dreg %h want 40 a5a5a5a5", mon_address, MonDReg); end
    issue(1'b1, 1'b0, 1'b0, jdo_addr(8'h20, 1'b0));
    run_txn(0, 0, 32'h0, 0);
    n_cmp++; if (monitor_error !== 1'b0 || mon_address !== 8'h20) begin n_bad++; $display("FAIL to_clear: got err %b addr %h want 0 20", monitor_error, mon_address); end
  endtask

  task automatic test_busy_and_simultaneous;
    issue(1'b0, 1'b0, 1'b1, 38'h0);
    run_txn(0, 3, 32'h7777_7777, 2);
    n_cmp++; if (monitor_error !== 1'b1) begin n_bad++; $display("FAIL busy_err: got %b want 1", monitor_error); end
    n_cmp++; if (MonDReg !== 32'h7777_7777 || mon_address !== 8'h21 || done !== 1'b1) begin n_bad++; $display("FAIL busy_cont: got %h addr %h done %b want 77777777 21 1", MonDReg, mon_address, done); end
    issue(1'b1, 1'b1, 1'b0, jdo_data(32'h89AB_CDEF) | (38'(1) << 17));
    run_txn(0, 0, 32'h0, 0);
    n_cmp++; if (wr_cyc !== 1 || rd_cyc !== 0 || wdata_seen !== 32'h89AB_CDEF) begin n_bad++; $display("FAIL simul_wr: got wr %0d rd %0d data %h want 1 0 89abcdef", wr_cyc, rd_cyc, wdata_seen); end
    n_cmp++; if (addr_seen !== 8'h21 || mon_address !== 8'h22 || monitor_error !== 1'b0) begin n_bad++; $display("FAIL simul_addr: got @%h next %h err %b want 21 22 0", addr_seen, mon_address, monitor_error); end
  endtask

  task automatic test_reset_mid_txn;
    issue(1'b0, 1'b0, 1'b1, 38'h0);
    @(negedge clk);
    take_no_action_ocimem_a = 1'b0;
    mon_waitrequest         = 1'b1;
    reset_n                 = 1'b0;
    @(negedge clk);
    reset_n         = 1'b1;
    mon_waitrequest = 1'b0;
    n_cmp++; if ({mon_read, monitor_ready, monitor_error} !== 3'b010 || mon_address !== 8'h00) begin n_bad++; $display("FAIL reset_abort: got rd/rdy/err %b addr %h want 010 00", {mon_read, monitor_ready, monitor_error}, mon_address); end
  endtask

  initial begin
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    mon_readdata = '0;
    mon_waitrequest = 1'b0;
    mon_readdatavalid = 1'b0;
    test_reset;
    test_addr_read;
    test_write_read_next;
    test_wrap;
    test_timeout;
    test_busy_and_simultaneous;
    test_reset_mid_txn;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
